counter_bin_engine: RTL

Parametrised multi-channel photon/event counter core that succeeds the fixed 4-channel counter. It supports CH_NUM channels of CNT_W-bit counters and per-channel edge or level counting. It provides immediate, triggered (with predelay) and gated acquisition, plus repetition accumulation per bin. Completed bins stream out over a valid/ready interface to the bin memory and system-bus wrapper, which also drives the cfg/cmd ports.

---
 rtl/counter_bin_engine.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/counter_bin_engine.sv
// Multi-channel event counter: immediate, triggered and gated windows with repetition
// accumulation per bin; finished bins leave on a valid/ready stream.
//
// state  | meaning
// IDLE   | waiting for a start command
// IMM    | immediate window running
// ARMED  | waiting for trigger edge or swTrigger
// PREDLY | delay between trigger and window start
// COUNT  | triggered window running
// GARMED | waiting for the gate to assert
// GCOUNT | gated window, ends when the gate deasserts
// STORE  | bin result held on m_* until accepted
module counter_bin_engine #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 32,
    parameter int BIN_W  = 12,
    parameter int TMO_W  = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic [CH_NUM-1:0]          inputs,
    input  logic [TMO_W-1:0]           cfg_timeout,
    input  logic [TMO_W-1:0]           cfg_predelay,
    input  logic [BIN_W:0]             cfg_nbins,
    input  logic [15:0]                cfg_reps,
    input  logic [$clog2(CH_NUM)-1:0]  cfg_trg_sel,
    input  logic                       cfg_trg_pol,
    input  logic [CH_NUM-1:0]          cfg_edge_mask,
    input  logic                       cmd_valid,
    input  logic [2:0]                 cmd_code,
    output logic [3:0]                 state,
    output logic [BIN_W-1:0]           bin_idx,
    output logic                       busy,
    output logic                       done,
    output logic [CH_NUM-1:0]          overflow,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [BIN_W-1:0]           m_bin,
    output logic [CH_NUM*CNT_W-1:0]    m_data
);

    localparam int SEL_W = $clog2(CH_NUM);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_IMM    = 4'd2,
        S_ARMED  = 4'd3,
        S_PREDLY = 4'd5,
        S_COUNT  = 4'd7,
        S_GARMED = 4'd8,
        S_GCOUNT = 4'd9,
        S_STORE  = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        MODE_IMM  = 2'd0,
        MODE_TRG  = 2'd1,
        MODE_GATE = 2'd2
    } mode_e;

    state_e                       state_q, state_d;
    mode_e                        mode_q;
    logic [TMO_W-1:0]             tmr_q, tmr_d;
    logic [15:0]                  rep_q, rep_d;
    logic [TMO_W-1:0]             timeout_q, predelay_q;
    logic [BIN_W:0]               nbins_q;
    logic [15:0]                  reps_q;
    logic [SEL_W-1:0]             trg_sel_q;
    logic                         trg_pol_q;
    logic [CH_NUM-1:0]            edge_mask_q;
    logic [CH_NUM-1:0]            prev_q;
    logic [CH_NUM-1:0]            ovf_q;
    logic [CH_NUM-1:0][CNT_W-1:0] cnt_q;
    logic [BIN_W-1:0]             bin_q;
    logic                         done_q;

    logic cmd_rst, cmd_abort, cmd_kill, cmd_sw;
    logic cmd_imm, cmd_trg, cmd_gate, cmd_start;
    logic trg_act, trg_act_prev, trg_start;
    logic tmr_zero, reps_done, last_bin, run_last, store_hs, cnt_en;
    logic [TMO_W-1:0]  tmo_in;
    logic [BIN_W:0]    nbins_in;
    logic [CH_NUM-1:0] hit;

    assign cmd_rst   = cmd_valid && (cmd_code == 3'd1);
    assign cmd_abort = cmd_valid && (cmd_code == 3'd6);
    assign cmd_kill  = cmd_rst || cmd_abort;
    assign cmd_sw    = cmd_valid && (cmd_code == 3'd5);
    assign cmd_imm   = cmd_valid && (cmd_code == 3'd2) && (state_q == S_IDLE);
    assign cmd_trg   = cmd_valid && (cmd_code == 3'd3) && (state_q == S_IDLE);
    assign cmd_gate  = cmd_valid && (cmd_code == 3'd4) && (state_q == S_IDLE);
    assign cmd_start = cmd_imm || cmd_trg || cmd_gate;

    assign tmo_in   = (cfg_timeout == '0) ? TMO_W'(1) : cfg_timeout;
    assign nbins_in = (cfg_nbins == '0) ? (BIN_W+1)'(1) : cfg_nbins;

    // Trigger edge and gate assertion are the same event: the selected channel becoming active.
    assign trg_act      = ~(inputs[trg_sel_q] ^ trg_pol_q);
    assign trg_act_prev = ~(prev_q[trg_sel_q] ^ trg_pol_q);
    assign trg_start    = trg_act && !trg_act_prev;

    assign tmr_zero  = (tmr_q == '0);
    assign reps_done = (rep_q == reps_q);
    assign last_bin  = (({1'b0, bin_q} + (BIN_W+1)'(1)) == nbins_q);
    assign run_last  = (mode_q == MODE_IMM) || last_bin;
    assign store_hs  = (state_q == S_STORE) && m_ready && !cmd_kill;

    // The gate-assert cycle is the first cycle of a gated window, so the window equals gate-high time.
    assign cnt_en = (state_q == S_IMM) || (state_q == S_COUNT)
                 || ((state_q == S_GCOUNT) && trg_act)
                 || ((state_q == S_GARMED) && trg_start);

    assign hit = cnt_en ? ((edge_mask_q & inputs & ~prev_q) | (~edge_mask_q & inputs)) : '0;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rep_q   <= rep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rep_d   = rep_q;
        unique case (state_q)
            S_IDLE: begin
                rep_d = '0;
                if (cmd_imm) begin
                    state_d = S_IMM;
                    tmr_d   = tmo_in - TMO_W'(1);
                end else if (cmd_trg) begin
                    state_d = S_ARMED;
                end else if (cmd_gate) begin
                    state_d = S_GARMED;
                end
            end
            S_IMM, S_COUNT: begin
                if (!tmr_zero) begin
                    tmr_d = tmr_q - TMO_W'(1);
                end else if (reps_done) begin
                    state_d = S_STORE;
                    rep_d   = '0;
                end else begin
                    rep_d = rep_q + 16'd1;
                    if (state_q == S_IMM) tmr_d = timeout_q - TMO_W'(1);
                    else                  state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (trg_start || cmd_sw) begin
                    if (predelay_q != '0) begin
                        state_d = S_PREDLY;
                        tmr_d   = predelay_q - TMO_W'(1);
                    end else begin
                        state_d = S_COUNT;
                        tmr_d   = timeout_q - TMO_W'(1);
                    end
                end
            end
            S_PREDLY: begin
                if (!tmr_zero) begin
                    tmr_d = tmr_q - TMO_W'(1);
                end else begin
                    state_d = S_COUNT;
                    tmr_d   = timeout_q - TMO_W'(1);
                end
            end
            S_GARMED: begin
                if (trg_start) state_d = S_GCOUNT;
            end
            S_GCOUNT: begin
                if (!trg_act) begin
                    if (reps_done) begin
                        state_d = S_STORE;
                        rep_d   = '0;
                    end else begin
                        state_d = S_GARMED;
                        rep_d   = rep_q + 16'd1;
                    end
                end
            end
            S_STORE: begin
                if (m_ready) begin
                    if (run_last)                   state_d = S_IDLE;
                    else if (mode_q == MODE_GATE)   state_d = S_GARMED;
                    else                            state_d = S_ARMED;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (cmd_kill) begin
            state_d = S_IDLE;
            tmr_d   = '0;
            rep_d   = '0;
        end
    end

    always_comb begin
        state    = state_q;
        busy     = (state_q != S_IDLE);
        m_valid  = (state_q == S_STORE);
        bin_idx  = bin_q;
        m_bin    = bin_q;
        done     = done_q;
        overflow = ovf_q;
        m_data   = cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mode_q      <= MODE_IMM;
            timeout_q   <= '0;
            predelay_q  <= '0;
            nbins_q     <= '0;
            reps_q      <= '0;
            trg_sel_q   <= '0;
            trg_pol_q   <= 1'b0;
            edge_mask_q <= '0;
            prev_q      <= '0;
            ovf_q       <= '0;
            cnt_q       <= '0;
            bin_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            prev_q <= inputs;
            done_q <= store_hs && run_last;
            if (cmd_start) begin
                timeout_q   <= tmo_in;
                predelay_q  <= cfg_predelay;
                nbins_q     <= nbins_in;
                reps_q      <= cfg_reps;
                trg_sel_q   <= cfg_trg_sel;
                trg_pol_q   <= cfg_trg_pol;
                edge_mask_q <= cfg_edge_mask;
                mode_q      <= cmd_imm ? MODE_IMM : (cmd_trg ? MODE_TRG : MODE_GATE);
            end
            if (cmd_rst || cmd_start) begin
                bin_q <= '0;
            end else if (store_hs) begin
                bin_q <= run_last ? '0 : bin_q + BIN_W'(1);
            end
            if (cmd_kill || cmd_start || store_hs) begin
                cnt_q <= '0;
            end else begin
                for (int c = 0; c < CH_NUM; c++) begin
                    if (hit[c] && !(&cnt_q[c])) cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                end
            end
            if (cmd_rst || cmd_start) begin
                ovf_q <= '0;
            end else begin
                for (int c = 0; c < CH_NUM; c++) begin
                    if (hit[c] && (&cnt_q[c])) ovf_q[c] <= 1'b1;
                end
            end
        end
    end

endmodule
